// File: rtl/float_mul_iter.sv
// float_mul_iter: iterative floating-point multiplier.
//
// Shift-add multiplies the two significands a few bits per cycle, then
// normalises, optionally rounds, and range-checks the exponent.
// Zero or all-ones exponent operands are answered immediately from IDLE.
//
// Optional feature macro: FLOAT_MUL_ITER_RNE_EN
//   defined   -> round to nearest, ties to even (guard + sticky)
//   undefined -> truncate discarded product bits
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   req   in   start request, only accepted while idle
//   a, b  in   operands {sign, exp, mant}
//   busy  out  high while an operation is in flight
//   ack   out  one-cycle result-valid pulse
//   out   out  product, valid while ack=1, otherwise 0
//
// state | meaning
// IDLE  | waiting for req; special operands are answered here
// MUL   | shift-add BITS_PER_CYCLE multiplier bits per cycle
// NORM  | normalise, round, range-check, emit ack
module float_mul_iter #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANT_WIDTH     = 23,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] b,
    output logic                          busy,
    output logic                          ack,
    output logic [EXP_WIDTH+MANT_WIDTH:0] out
);
    localparam int W  = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int SW = MANT_WIDTH + 1;
    localparam int PW = 2 * SW;
    localparam int N  = SW / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    localparam logic signed [EXP_WIDTH+1:0] BIAS     = {3'b000, {(EXP_WIDTH-1){1'b1}}};
    localparam logic signed [EXP_WIDTH+1:0] EXP_MAX  = {2'b00, {EXP_WIDTH{1'b1}}};
    localparam logic signed [EXP_WIDTH+1:0] EXP_ZERO = '0;

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [SW-1:0]        ma, ma_n;
    logic [PW-1:0]        mb, mb_n;
    logic [PW-1:0]        acc, acc_n;
    logic                 sgn, sgn_n;
    logic [EXP_WIDTH-1:0] ea, ea_n, eb, eb_n;
    logic                 busy_n, ack_n;
    logic [W-1:0]         out_n;

    logic [EXP_WIDTH-1:0] a_exp, b_exp;
    assign a_exp = a[W-2 -: EXP_WIDTH];
    assign b_exp = b[W-2 -: EXP_WIDTH];

    // Multiplier slice zero-extended so the product stays at accumulator width;
    // mb is pre-shifted to the slice's weight.
    logic [PW-1:0] mplr, partial;
    assign mplr    = {{(PW-BITS_PER_CYCLE){1'b0}}, ma[BITS_PER_CYCLE-1:0]};
    assign partial = mplr * mb;

    // Normalisation of the finished product.
    logic                          top;
    logic [MANT_WIDTH-1:0]         mant_t, mant_r;
    logic signed [EXP_WIDTH+1:0]   exp_s, exp_r;
    logic [W-1:0]                  norm_res;
`ifdef FLOAT_MUL_ITER_RNE_EN
    logic guard, sticky, rnd, carry;
`endif

    always_comb begin
        top    = acc[PW-1];
        mant_t = top ? acc[PW-2 -: MANT_WIDTH] : acc[PW-3 -: MANT_WIDTH];
        exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
                 + $signed({{(EXP_WIDTH+1){1'b0}}, top});
`ifdef FLOAT_MUL_ITER_RNE_EN
        guard  = top ? acc[SW-1] : acc[MANT_WIDTH-1];
        sticky = top ? (|acc[SW-2:0]) : (|acc[MANT_WIDTH-2:0]);
        rnd    = guard & (sticky | mant_t[0]);
        // A carry out means the significand reached 2.0: mantissa wraps to
        // zero and the exponent absorbs the extra bit.
        {carry, mant_r} = {1'b0, mant_t} + {{MANT_WIDTH{1'b0}}, rnd};
        exp_r  = exp_s + $signed({{(EXP_WIDTH+1){1'b0}}, carry});
`else
        mant_r = mant_t;
        exp_r  = exp_s;
`endif
        if (exp_r >= EXP_MAX)
            norm_res = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else if (exp_r <= EXP_ZERO)
            norm_res = '0;
        else
            norm_res = {sgn, exp_r[EXP_WIDTH-1:0], mant_r};
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ma_n    = ma;
        mb_n    = mb;
        acc_n   = acc;
        sgn_n   = sgn;
        ea_n    = ea;
        eb_n    = eb;
        ack_n   = 1'b0;
        out_n   = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (a_exp == '0 || b_exp == '0) begin
                        ack_n = 1'b1;
                    end else if (&a_exp || &b_exp) begin
                        ack_n = 1'b1;
                        out_n = {a[W-1] ^ b[W-1], {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    end else begin
                        state_n = MUL;
                        cnt_n   = CW'(N - 1);
                        ma_n    = {1'b1, a[MANT_WIDTH-1:0]};
                        mb_n    = {{SW{1'b0}}, 1'b1, b[MANT_WIDTH-1:0]};
                        acc_n   = '0;
                        sgn_n   = a[W-1] ^ b[W-1];
                        ea_n    = a_exp;
                        eb_n    = b_exp;
                    end
                end
            end
            MUL: begin
                acc_n = acc + partial;
                ma_n  = ma >> BITS_PER_CYCLE;
                mb_n  = mb << BITS_PER_CYCLE;
                cnt_n = cnt - CW'(1);
                if (cnt == '0)
                    state_n = NORM;
            end
            NORM: begin
                ack_n   = 1'b1;
                out_n   = norm_res;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            sgn   <= 1'b0;
            ea    <= '0;
            eb    <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ma    <= ma_n;
            mb    <= mb_n;
            acc   <= acc_n;
            sgn   <= sgn_n;
            ea    <= ea_n;
            eb    <= eb_n;
            busy  <= busy_n;
            ack   <= ack_n;
            out   <= out_n;
        end
    end
endmodule

// File: doc/float_mul_iter.md
FLOAT_MUL_ITER -- requirements
Module: float_mul_iter

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8: exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23: stored mantissa width, excluding the hidden one.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 2: multiplier bits retired per MUL cycle; legal values divide MANT_WIDTH+1 exactly.
REQ-004 SHALL have port clk  input  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req  input  1  start request, registered by the caller.
REQ-007 SHALL have port a  input  1+EXP_WIDTH+MANT_WIDTH  operand A as {sign, exp, mant}.
REQ-008 SHALL have port b  input  1+EXP_WIDTH+MANT_WIDTH  operand B, same format as a.
REQ-009 SHALL have port busy  output  1  registered; high while not IDLE.
REQ-010 SHALL have port ack  output  1  registered; one-cycle result-valid pulse.
REQ-011 SHALL have port out  output  1+EXP_WIDTH+MANT_WIDTH  registered product; valid only while ack=1, otherwise 0.

Function
REQ-012 SHALL implement states IDLE, MUL and NORM; IDLE->MUL on accepted nonspecial req; MUL->NORM after N=(MANT_WIDTH+1)/BITS_PER_CYCLE MUL cycles; NORM->IDLE unconditionally.
REQ-013 SHALL accept req only in IDLE; req while busy=1 is ignored (no queueing, no ack).
REQ-014 SHALL capture a and b on the accepting edge; input changes afterwards do not affect the result.
REQ-015 SHALL, when either operand exponent is 0, return out=0 (sign 0) with ack at the accepting edge and stay IDLE.
REQ-016 SHALL, otherwise, when either operand exponent is all-ones, return infinity ({a.sign^b.sign, all-ones exp, zero mant}) with ack at the accepting edge; zero operands take precedence.
REQ-017 SHALL, in each MUL cycle, shift-add BITS_PER_CYCLE bits of A's significand (hidden one restored) times B's significand into a 2*(MANT_WIDTH+1)-bit product accumulator, LSB first.
REQ-018 SHALL, in NORM, shift the product right by MANT_WIDTH+1 if its top bit is set, else by MANT_WIDTH, and compute exponent = ea+eb-bias (+1 if top bit), with bias = 2^(EXP_WIDTH-1)-1, using a signed intermediate of EXP_WIDTH+2 bits.
REQ-019 SHALL, when the final exponent is at or above all-ones, return signed infinity; when it is at or below 0, return +0.
REQ-020 SHALL set sign = a.sign ^ b.sign for nonzero results.
REQ-021 SHALL, for nonspecial operands, assert ack and out for exactly one cycle, N+1 edges after the accepting edge (13 for the default parameters).

Reset
REQ-022 SHALL, on rst, go to IDLE with busy=0, ack=0, out=0 and clear all datapath registers.
REQ-023 SHALL, when rst asserts mid-operation, abort the operation and never emit its ack.
REQ-024 SHALL accept req on the first edge after rst deasserts.

Configuration
REQ-025 SHALL, with FLOAT_MUL_ITER_RNE_EN defined, round to nearest, ties to even, using guard and sticky bits of the discarded product bits; a rounding mantissa carry-out increments the exponent, and the overflow check of REQ-019 applies afterwards.
REQ-026 SHALL, without FLOAT_MUL_ITER_RNE_EN, truncate the discarded bits, with no rounding logic present.

Verification
REQ-027 SHALL test: a=0x3FC00000, b=0x40000000, req pulse -> busy for 13 cycles, then ack=1, out=0x40400000 (1.5*2=3).
REQ-028 SHALL test: a=0xC0000000, b=0x40400000 -> out=0xC0C00000; a=0x00000000, b=0x40490FDB -> ack on the next cycle, out=0x00000000.
REQ-029 SHALL test: a=0x7F000000, b=0x7F000000 -> out=0x7F800000; a=0x00800000, b=0x00800000 -> out=0x00000000.
REQ-030 SHALL test: a=0x3FC00001, b=0x3FC00000 -> out=0x40100001 with FLOAT_MUL_ITER_RNE_EN defined, 0x40100000 without it.
REQ-031 SHALL test: second req with new operands 3 cycles after the first -> exactly one ack, carrying the first result; operands changed mid-MUL -> result unchanged.
REQ-032 SHALL test: rst pulsed at MUL cycle 5 -> busy=0, no ack; a fresh req then completes normally in 13 cycles.
